// File: rtl/pipeline_hazard_control_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_control_pkg : LC-3b types and hazard-control definitions
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipeline_hazard_control_pkg;

  typedef logic [3:0] lc3b_opcode;
  typedef logic [2:0] lc3b_reg;

  localparam lc3b_opcode op_br   = 4'h0;
  localparam lc3b_opcode op_add  = 4'h1;
  localparam lc3b_opcode op_ldb  = 4'h2;
  localparam lc3b_opcode op_stb  = 4'h3;
  localparam lc3b_opcode op_jsr  = 4'h4;
  localparam lc3b_opcode op_and  = 4'h5;
  localparam lc3b_opcode op_ldr  = 4'h6;
  localparam lc3b_opcode op_str  = 4'h7;
  localparam lc3b_opcode op_rti  = 4'h8;
  localparam lc3b_opcode op_not  = 4'h9;
  localparam lc3b_opcode op_ldi  = 4'ha;
  localparam lc3b_opcode op_sti  = 4'hb;
  localparam lc3b_opcode op_jmp  = 4'hc;
  localparam lc3b_opcode op_shf  = 4'hd;
  localparam lc3b_opcode op_lea  = 4'he;
  localparam lc3b_opcode op_trap = 4'hf;

  typedef enum logic [1:0] {
    IND_IDLE   = 2'd0,
    IND_FIRST  = 2'd1,
    IND_SECOND = 2'd2
  } lc3b_ind_state;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } lc3b_pipe_ctrl;

  localparam lc3b_pipe_ctrl CTRL_RESET    = 8'b00000_111;
  localparam lc3b_pipe_ctrl CTRL_FREEZE   = 8'b00000_000;
  localparam lc3b_pipe_ctrl CTRL_FLUSH    = 8'b11111_111;
  localparam lc3b_pipe_ctrl CTRL_LOAD_USE = 8'b00111_010;
  localparam lc3b_pipe_ctrl CTRL_RUN      = 8'b11111_000;

  function automatic logic is_indirect(input lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

  // Opcodes whose result only exists after the MEM-stage read
  function automatic logic is_load(input lc3b_opcode op);
    return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_control_indirect.sv
// ----------------------------------------------------------------------------
// indirect_access_fsm : sequences the two data accesses of LDI/STI
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module indirect_access_fsm
  import pipeline_hazard_control_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ind,
  input  logic          dmem_resp,
  output lc3b_ind_state state,
  output logic          ind_ptr_load,
  output logic          ind_addr_sel
);

  lc3b_ind_state state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IND_IDLE:   if (ind)       state_d = IND_FIRST;
      IND_FIRST:  if (dmem_resp) state_d = IND_SECOND;
      IND_SECOND: if (dmem_resp) state_d = IND_IDLE;
      default:                   state_d = IND_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IND_IDLE;
    else       state_q <= state_d;
  end

  assign state = state_q;
  // Gated by reset so a pointer mux held mid-indirect never leaks through
  assign ind_ptr_load = !reset && (state_q == IND_FIRST) && dmem_resp;
  assign ind_addr_sel = !reset && (state_q == IND_SECOND);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_control.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_control : stall/flush sequencer for the LC-3b 5-stage pipe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_control
  import pipeline_hazard_control_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [2:0]           id_sr1,
  input  logic [2:0]           id_sr2,
  input  logic                 id_sr1_used,
  input  logic                 id_sr2_used,
  input  logic                 ex_valid,
  input  logic [3:0]           ex_opcode,
  input  logic [2:0]           ex_dest,
  input  logic                 ex_regwrite,
  input  logic                 mem_valid,
  input  logic [3:0]           mem_opcode,
  input  logic                 mem_branch_taken,
  input  logic                 imem_req,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 ind_ptr_load,
  output logic                 ind_addr_sel,
  output logic [CNT_WIDTH-1:0] load_use_cnt,
  output logic [CNT_WIDTH-1:0] mem_wait_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  lc3b_ind_state ind_state;
  lc3b_pipe_ctrl ctrl;
  logic          ind;
  logic          load_use;
  logic          mem_wait;
  logic          ev_wait, ev_flush, ev_load_use;

  logic [CNT_WIDTH-1:0] load_use_cnt_q, load_use_cnt_d;
  logic [CNT_WIDTH-1:0] mem_wait_cnt_q, mem_wait_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  assign ind = mem_valid && is_indirect(mem_opcode);

  indirect_access_fsm u_ind_fsm (
    .clk          (clk),
    .reset        (reset),
    .ind          (ind),
    .dmem_resp    (dmem_resp),
    .state        (ind_state),
    .ind_ptr_load (ind_ptr_load),
    .ind_addr_sel (ind_addr_sel)
  );

  // An indirect op holds MEM until the second access returns
  assign mem_wait = (dmem_req && !dmem_resp) ||
                    (imem_req && !imem_resp) ||
                    (ind && !((ind_state == IND_SECOND) && dmem_resp));

  assign load_use = ex_valid && ex_regwrite && id_valid && is_load(ex_opcode) &&
                    ((id_sr1_used && (id_sr1 == ex_dest)) ||
                     (id_sr2_used && (id_sr2 == ex_dest)));

  always_comb begin
    ctrl        = CTRL_RUN;
    ev_wait     = 1'b0;
    ev_flush    = 1'b0;
    ev_load_use = 1'b0;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (mem_wait) begin
      ctrl    = CTRL_FREEZE;
      ev_wait = 1'b1;
    end else if (mem_branch_taken) begin
      ctrl     = CTRL_FLUSH;
      ev_flush = 1'b1;
    end else if (load_use) begin
      ctrl        = CTRL_LOAD_USE;
      ev_load_use = 1'b1;
    end
  end

  always_comb begin
    load_use_cnt_d = load_use_cnt_q;
    mem_wait_cnt_d = mem_wait_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    if (ev_load_use && (load_use_cnt_q != CNT_MAX)) load_use_cnt_d = load_use_cnt_q + CNT_ONE;
    if (ev_wait     && (mem_wait_cnt_q != CNT_MAX)) mem_wait_cnt_d = mem_wait_cnt_q + CNT_ONE;
    if (ev_flush    && (flush_cnt_q    != CNT_MAX)) flush_cnt_d    = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_use_cnt_q <= '0;
      mem_wait_cnt_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      load_use_cnt_q <= load_use_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign pc_load      = ctrl.pc_load;
  assign if_id_load   = ctrl.if_id_load;
  assign id_ex_load   = ctrl.id_ex_load;
  assign ex_mem_load  = ctrl.ex_mem_load;
  assign mem_wb_load  = ctrl.mem_wb_load;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign load_use_cnt = load_use_cnt_q;
  assign mem_wait_cnt = mem_wait_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_control.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_control : directed self-checking bench
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid, id_sr1_used, id_sr2_used;
  logic [2:0] id_sr1, id_sr2, ex_dest;
  logic       ex_valid, ex_regwrite, mem_valid, mem_branch_taken;
  logic [3:0] ex_opcode, mem_opcode;
  logic       imem_req, imem_resp, dmem_req, dmem_resp;

  logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, ind_ptr_load, ind_addr_sel;
  logic [15:0] load_use_cnt, mem_wait_cnt, flush_cnt;

  logic        s_pc_load, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_ind_ptr_load, s_ind_addr_sel;
  logic [1:0]  s_load_use_cnt, s_mem_wait_cnt, s_flush_cnt;

  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_LDR = 4'h6, OP_LDI = 4'ha;

  localparam logic [7:0] C_RESET = 8'b00000_111;
  localparam logic [7:0] C_FREEZE = 8'b00000_000;
  localparam logic [7:0] C_FLUSH = 8'b11111_111;
  localparam logic [7:0] C_LU = 8'b00111_010;
  localparam logic [7:0] C_RUN = 8'b11111_000;

  wire [7:0] ctrl = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                     if_id_flush, id_ex_flush, ex_mem_flush};

  pipeline_hazard_control #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_branch_taken(mem_branch_taken),
    .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .ind_ptr_load(ind_ptr_load), .ind_addr_sel(ind_addr_sel),
    .load_use_cnt(load_use_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance on the same stimulus exposes saturation quickly
  pipeline_hazard_control #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_branch_taken(mem_branch_taken),
    .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(s_pc_load), .if_id_load(s_if_id_load), .id_ex_load(s_id_ex_load),
    .ex_mem_load(s_ex_mem_load), .mem_wb_load(s_mem_wb_load),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
    .ind_ptr_load(s_ind_ptr_load), .ind_addr_sel(s_ind_addr_sel),
    .load_use_cnt(s_load_use_cnt), .mem_wait_cnt(s_mem_wait_cnt), .flush_cnt(s_flush_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_sr1_used = 0; id_sr2_used = 0;
    ex_valid = 0; ex_opcode = OP_ADD; ex_dest = 0; ex_regwrite = 0;
    mem_valid = 0; mem_opcode = OP_ADD; mem_branch_taken = 0;
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
  endtask

  // LDR R3 in EX feeding ADD R1,R3,R2 in ID
  task automatic set_load_use();
    ex_valid = 1; ex_opcode = OP_LDR; ex_dest = 3'd3; ex_regwrite = 1;
    id_valid = 1; id_sr1 = 3'd3; id_sr2 = 3'd2; id_sr1_used = 1; id_sr2_used = 1;
  endtask

  initial begin
    reset = 1; idle();
    tick(); tick();
    check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    check("reset_ind", {30'd0, ind_ptr_load, ind_addr_sel}, 32'd0);
    check("reset_cnts", {load_use_cnt, flush_cnt}, 32'd0);

    reset = 0; #1;
    check("run_ctrl", 32'(ctrl), 32'(C_RUN));

    // load-use: one bubble, then released
    set_load_use(); #1;
    check("lu_ctrl", 32'(ctrl), 32'(C_LU));
    tick();
    ex_valid = 0; #1;
    check("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
    check("lu_cnt1", 32'(load_use_cnt), 32'd1);

    // non-hazards: sr2 match but unused, and non-load producer
    set_load_use(); ex_opcode = OP_LDB; id_sr1 = 3'd0; id_sr2 = 3'd3; id_sr2_used = 0; #1;
    check("lu_unused_src", 32'(ctrl), 32'(C_RUN));
    set_load_use(); ex_opcode = OP_ADD; #1;
    check("lu_alu_prod", 32'(ctrl), 32'(C_RUN));
    set_load_use(); ex_opcode = OP_LDB; id_sr1_used = 0; id_sr2 = 3'd3; #1;
    check("lu_ldb_sr2", 32'(ctrl), 32'(C_LU));
    idle();
    tick();
    check("lu_cnt2", 32'(load_use_cnt), 32'd1);

    // dmem wait for three cycles, released on the response cycle
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("dwait%0d", i), 32'(ctrl), 32'(C_FREEZE));
      tick();
    end
    dmem_resp = 1; #1;
    check("dwait_release", 32'(ctrl), 32'(C_RUN));
    tick();
    idle(); #1;
    check("mw_cnt3", 32'(mem_wait_cnt), 32'd3);
    imem_req = 1; #1;
    check("iwait", 32'(ctrl), 32'(C_FREEZE));
    tick();
    idle();

    // LDI: FIRST, FIRST(resp -> ptr pulse), SECOND(resp -> release)
    mem_valid = 1; mem_opcode = OP_LDI; dmem_req = 1; #1;
    check("ldi_c0", {24'd0, ctrl}, {24'd0, C_FREEZE});
    check("ldi_c0_ind", {30'd0, ind_ptr_load, ind_addr_sel}, 32'd0);
    tick();
    check("ldi_c1", {22'd0, ind_ptr_load, ind_addr_sel, ctrl}, {22'd0, 2'b00, C_FREEZE});
    tick();
    dmem_resp = 1; #1;
    check("ldi_c2", {22'd0, ind_ptr_load, ind_addr_sel, ctrl}, {22'd0, 2'b10, C_FREEZE});
    tick();
    check("ldi_c3", {22'd0, ind_ptr_load, ind_addr_sel, ctrl}, {22'd0, 2'b01, C_RUN});
    tick();
    idle(); #1;
    check("ldi_done_ind", {30'd0, ind_ptr_load, ind_addr_sel}, 32'd0);
    check("mw_cnt7", 32'(mem_wait_cnt), 32'd7);

    // taken branch overrides load-use
    set_load_use(); mem_valid = 1; mem_opcode = OP_BR; mem_branch_taken = 1; #1;
    check("br_lu_ctrl", 32'(ctrl), 32'(C_FLUSH));
    tick();
    check("br_cnts", {load_use_cnt, flush_cnt}, {16'd1, 16'd1});

    // branch held in frozen MEM, flush on release
    dmem_req = 1; dmem_resp = 0; #1;
    check("br_wait", 32'(ctrl), 32'(C_FREEZE));
    tick();
    dmem_resp = 1; #1;
    check("br_release", 32'(ctrl), 32'(C_FLUSH));
    tick();
    idle(); #1;
    check("br_cnts2", {mem_wait_cnt, flush_cnt}, {16'd8, 16'd2});
    check("sat_mw", 32'(s_mem_wait_cnt), 32'd3);
    check("sat_fl", 32'(s_flush_cnt), 32'd2);

    // saturation: narrow counter 1 -> 3 and holds, wide keeps counting
    for (int i = 0; i < 3; i++) begin
      set_load_use();
      tick();
      if (i == 1) check("sat_lu_at_max", 32'(s_load_use_cnt), 32'd3);
    end
    idle(); #1;
    check("sat_lu_hold", 32'(s_load_use_cnt), 32'd3);
    check("lu_cnt4", 32'(load_use_cnt), 32'd4);

    // reset while in IND_SECOND
    mem_valid = 1; mem_opcode = OP_LDI; dmem_req = 1; dmem_resp = 1;
    tick(); tick(); #1;
    check("rst_in_second_sel", 32'(ind_addr_sel), 32'd1);
    reset = 1; #1;
    check("rst_held_ctrl", 32'(ctrl), 32'(C_RESET));
    check("rst_held_ind", {30'd0, ind_ptr_load, ind_addr_sel}, 32'd0);
    tick();
    check("rst_cnts", {load_use_cnt, mem_wait_cnt}, 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    reset = 0; #1;
    // back in IND_IDLE, so LDI with resp is a first access and freezes
    check("rst_state_idle", {22'd0, ind_ptr_load, ind_addr_sel, ctrl}, {22'd0, 2'b00, C_FREEZE});
    tick();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
